// File: rtl/key_debouncer_pkg.sv
// Shared constants for the key debouncer: key bit map, cell state encodings
// and small elaboration-time helpers.
package key_debouncer_pkg;

  localparam int KEY_W_DEF     = 18;
  localparam int NOTE_KEY_BITS = 7;
  localparam int KEY_SUBMIT    = 14;
  localparam int KEY_CANCEL    = 15;
  localparam int KEY_OCT_UP    = 16;
  localparam int KEY_OCT_DOWN  = 17;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [2:0] popcount_notes(input logic [NOTE_KEY_BITS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NOTE_KEY_BITS; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/key_debouncer_cell.sv
// Single-key debounce FSM. Advances only on the shared sample tick and needs
// STABLE_TICKS consecutive confirming samples after leaving a stable state.
//
//  state        | meaning
//  IDLE         | level 0, input agrees
//  PRESS_WAIT   | level 0, input seen high, counting confirmations
//  HELD         | level 1, input agrees
//  RELEASE_WAIT | level 1, input seen low, counting confirmations
module key_debounce_cell
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic sample_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic held_o
);

  localparam int CW = clog2_min1(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Next-state: transitions only on tick; counter clears on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          if (sample_i) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sample_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HELD: begin
          if (!sample_i) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        default: begin
          if (sample_i) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // State, counter and registered level/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign held_o  = (state_q == ST_HELD);

endmodule

// File: rtl/key_debouncer.sv
// Key input conditioner: 2-FF synchroniser, shared sample prescaler, one
// debounce cell per key, registered note decode, and optional octave-key
// auto-repeat enabled by defining KEY_DEBOUNCER_AUTOREPEAT_EN.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int KEY_W        = KEY_W_DEF,
  parameter int TICK_CYCLES  = 100000,
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 150
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [KEY_W-1:0]         key_raw,
  output logic [KEY_W-1:0]         key_level,
  output logic [KEY_W-1:0]         key_rise,
  output logic [KEY_W-1:0]         key_fall,
  output logic [NOTE_KEY_BITS-1:0] note_onehot,
  output logic                     note_multi
);

  localparam int PW = clog2_min1(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [KEY_W-1:0]         sync_meta_q, sync_q;
  logic [PW-1:0]            presc_q, presc_d;
  logic                     tick;
  logic [KEY_W-1:0]         cell_level, cell_rise, cell_fall, cell_held;
  logic [2:0]               note_cnt;
  logic [NOTE_KEY_BITS-1:0] note_onehot_q, note_onehot_d;
  logic                     note_multi_q, note_multi_d;
  logic                     unused_held;

  // Two-stage synchroniser for the asynchronous pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= key_raw;
      sync_q      <= sync_meta_q;
    end
  end

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // Free-running sample prescaler shared by all cells.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  for (genvar k = 0; k < KEY_W; k++) begin : g_cell
    key_debounce_cell #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_i  (tick),
      .sample_i(sync_q[k]),
      .level_o (cell_level[k]),
      .rise_o  (cell_rise[k]),
      .fall_o  (cell_fall[k]),
      .held_o  (cell_held[k])
    );
  end

  // Held state is only consumed by the repeat path.
  assign unused_held = ^cell_held;

  assign key_level = cell_level;
  assign key_fall  = cell_fall;

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int RW = clog2_min1(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [1:0]       rpt_pulse;
  logic [KEY_W-1:0] rpt_vec;

  for (genvar r = 0; r < 2; r++) begin : g_rpt
    localparam int B = (r == 0) ? KEY_OCT_UP : KEY_OCT_DOWN;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          pulse_q, pulse_d;

    // Count ticks spent staying in HELD; first period is the delay, then the rate.
    always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      pulse_d = 1'b0;
      if (tick) begin
        if (cell_held[B] && sync_q[B]) begin
          if (cnt_q == (armed_q ? RATE_LAST : DELAY_LAST)) begin
            cnt_d   = '0;
            armed_d = 1'b1;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + RW'(1);
          end
        end else begin
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
    end

    // Repeat counter and registered repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        armed_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        armed_q <= armed_d;
        pulse_q <= pulse_d;
      end
    end

    assign rpt_pulse[r] = pulse_q;
  end

  // Place repeat pulses on the octave key positions.
  always_comb begin
    rpt_vec               = '0;
    rpt_vec[KEY_OCT_UP]   = rpt_pulse[0];
    rpt_vec[KEY_OCT_DOWN] = rpt_pulse[1];
  end

  assign key_rise = cell_rise | rpt_vec;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
  assign key_rise = cell_rise;
`endif

  // Note decode from the debounced note levels.
  always_comb begin
    note_cnt      = popcount_notes(cell_level[NOTE_KEY_BITS-1:0]);
    note_onehot_d = (note_cnt == 3'd1) ? cell_level[NOTE_KEY_BITS-1:0] : '0;
    note_multi_d  = (note_cnt >= 3'd2);
  end

  // Registered note outputs, one clk behind key_level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_onehot_q <= '0;
      note_multi_q  <= 1'b0;
    end else begin
      note_onehot_q <= note_onehot_d;
      note_multi_q  <= note_multi_d;
    end
  end

  assign note_onehot = note_onehot_q;
  assign note_multi  = note_multi_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer with small timing parameters. A run-length model of
// the debounce rule is compared on every clk; directed tests pin key timings.
module tb_key_debouncer;

  localparam int KW = 18;
  localparam int TC = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RR = 2;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KW-1:0] key_raw = '0;
  logic [KW-1:0] key_level, key_rise, key_fall;
  logic [6:0]    note_onehot;
  logic          note_multi;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  key_debouncer #(
    .KEY_W       (KW),
    .TICK_CYCLES (TC),
    .STABLE_TICKS(ST),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_rise   (key_rise),
    .key_fall   (key_fall),
    .note_onehot(note_onehot),
    .note_multi (note_multi)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a key flips level once ST+1 consecutive tick samples disagree with it.
  bit [KW-1:0] lvl_m, rise_m, fall_m, prev_s_m, s1_m, s2_m;
  bit [6:0]    oh_m;
  bit          multi_m;
  int          run_m[KW];
  int          stay_m[KW];
  int          cyc_m;

  always @(posedge clk) begin
    if (!rst_n) begin
      lvl_m = '0; rise_m = '0; fall_m = '0; prev_s_m = '0; s1_m = '0; s2_m = '0;
      oh_m = '0; multi_m = 1'b0; cyc_m = 0;
      for (int k = 0; k < KW; k++) begin
        run_m[k] = 0;
        stay_m[k] = 0;
      end
    end else begin
      int n;
      rise_m = '0;
      fall_m = '0;
      n = $countones(lvl_m[6:0]);
      oh_m = (n == 1) ? lvl_m[6:0] : 7'd0;
      multi_m = (n >= 2);
      if (cyc_m % TC == TC - 1) begin
        for (int k = 0; k < KW; k++) begin
          bit s;
          bit held;
          s = s2_m[k];
          held = lvl_m[k] && prev_s_m[k];
          if (AR && (k == 16 || k == 17) && held && s) begin
            stay_m[k]++;
            if (stay_m[k] == RD || (stay_m[k] > RD && (stay_m[k] - RD) % RR == 0))
              rise_m[k] = 1'b1;
          end else begin
            stay_m[k] = 0;
          end
          if (s != lvl_m[k]) begin
            run_m[k]++;
            if (run_m[k] == ST + 1) begin
              lvl_m[k] = s;
              if (s) rise_m[k] = 1'b1;
              else   fall_m[k] = 1'b1;
              run_m[k] = 0;
            end
          end else begin
            run_m[k] = 0;
          end
          prev_s_m[k] = s;
        end
      end
      s2_m = s1_m;
      s1_m = key_raw;
      cyc_m++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      if (!rst_n) begin
        chk("rst_level", key_level, 0);
        chk("rst_rise", key_rise, 0);
        chk("rst_fall", key_fall, 0);
        chk("rst_onehot", note_onehot, 0);
        chk("rst_multi", note_multi, 0);
      end else begin
        chk("level", key_level, lvl_m);
        chk("rise", key_rise, rise_m);
        chk("fall", key_fall, fall_m);
        chk("onehot", note_onehot, oh_m);
        chk("multi", note_multi, multi_m);
      end
    end
  end

  // Negedges until a pulse on bit b (rise or fall); -1 when the budget expires.
  task automatic wait_pulse(input int b, input bit fall, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if ((fall ? key_fall[b] : key_rise[b]) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, pulses, rises, first, k, extra14;
    int offs[4];
    cmp_en = 1'b1;

    // 1: reset with all keys held
    rst_n = 1'b0;
    key_raw = 18'h3FFFF;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(0, 1'b0, 40, n);
    chk("t1_rise_latency", n, 16);
    chk("t1_rise_all", key_rise, 18'h3FFFF);
    chk("t1_level_all", key_level, 18'h3FFFF);
    chk("t1_model_level", lvl_m, 18'h3FFFF);
    @(negedge clk);
    chk("t1_rise_width", key_rise, 0);
    chk("t1_multi", note_multi, 1);
    chk("t1_onehot", note_onehot, 0);
    key_raw = '0;
    repeat (30) @(negedge clk);
    chk("t1_released", key_level, 0);

    // 2: bounce on bit0, then a steady press
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      key_raw[0] = (i % 2 == 0);
      repeat (4) begin
        @(negedge clk);
        pulses += int'(key_rise[0] | key_fall[0]);
      end
    end
    chk("t2_bounce_pulses", pulses, 0);
    key_raw[0] = 1'b1;
    rises = 0;
    first = -1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      rises += int'(key_rise[0]);
      if (first < 0 && key_level[0]) first = i;
    end
    chk("t2_single_rise", rises, 1);
    chk("t2_latency_min", first >= 15, 1);
    chk("t2_latency_max", (first > 0) && (first <= 18), 1);
    key_raw[0] = 1'b0;
    repeat (24) @(negedge clk);

    // 3: single note press and release
    key_raw[3] = 1'b1;
    repeat (24) @(negedge clk);
    chk("t3_level", key_level[3], 1);
    chk("t3_onehot", note_onehot, 7'b0001000);
    key_raw[3] = 1'b0;
    wait_pulse(3, 1'b1, 24, n);
    chk("t3_fall_seen", n > 0, 1);
    chk("t3_level_drop", key_level[3], 0);
    chk("t3_onehot_lag", note_onehot, 7'b0001000);
    @(negedge clk);
    chk("t3_fall_width", key_fall[3], 0);
    chk("t3_onehot_clear", note_onehot, 0);
    repeat (8) @(negedge clk);

    // 4: two notes, then one released
    key_raw[2:1] = 2'b11;
    repeat (24) @(negedge clk);
    chk("t4_multi", note_multi, 1);
    chk("t4_onehot_zero", note_onehot, 0);
    key_raw[2] = 1'b0;
    repeat (24) @(negedge clk);
    chk("t4_onehot_bit1", note_onehot, 7'b0000010);
    chk("t4_multi_clear", note_multi, 0);
    key_raw[1] = 1'b0;
    repeat (24) @(negedge clk);

    // 5: reset while submit is held
    key_raw[14] = 1'b1;
    repeat (24) @(negedge clk);
    chk("t5_held", key_level[14], 1);
    #2 rst_n = 1'b0;
    #1 chk("t5_level_async", key_level, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(14, 1'b0, 40, n);
    chk("t5_rise_latency", n, 16);
    chk("t5_rise_only14", key_rise, 18'h04000);
    key_raw[14] = 1'b0;
    repeat (24) @(negedge clk);

    // 6: octave-up and submit held together
    key_raw[16] = 1'b1;
    key_raw[14] = 1'b1;
    wait_pulse(16, 1'b0, 30, n);
    chk("t6_accept_latency", (n >= 15) && (n <= 18), 1);
    chk("t6_accept_14", key_rise[14], 1);
    k = 0;
    extra14 = 0;
    for (int i = 1; i < 48; i++) begin
      @(negedge clk);
      if (key_rise[16]) begin
        if (k < 4) offs[k] = i;
        k++;
      end
      extra14 += int'(key_rise[14]);
    end
    chk("t6_submit_no_repeat", extra14, 0);
    chk("t6_oct_level", key_level[16], 1);
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    chk("t6_repeat_count", k, 4);
    chk("t6_repeat_at_5", offs[0], 20);
    chk("t6_repeat_at_7", offs[1], 28);
    chk("t6_repeat_at_9", offs[2], 36);
    chk("t6_repeat_at_11", offs[3], 44);
`else
    chk("t6_repeat_count", k, 0);
`endif
    key_raw[16] = 1'b0;
    key_raw[14] = 1'b0;
    repeat (24) @(negedge clk);
    chk("t6_released", key_level, 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
